// File: rtl/cla_addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// cla_addsub_pipe_if
//
// Purpose:
//   Groups the operand-side and result-side valid/ready bundles of the
//   pipelined carry-lookahead adder/subtractor into one interface.
//
// Parameters:
//   WIDTH      operand/result width in bits
//
// Signals:
//   in_valid   upstream -> block   operand bundle valid
//   in_ready   block -> upstream   block can take a bundle this cycle
//   a, b       upstream -> block   operands
//   cin        upstream -> block   carry-in (add) / borrow-in (sub)
//   sub        upstream -> block   0 = add, 1 = subtract
//   out_valid  block -> downstream result bundle valid
//   out_ready  downstream -> block result accepted
//   sum        block -> downstream result modulo 2^WIDTH
//   cout       block -> downstream carry-out (add) / not-borrow (sub)
//   ovf        block -> downstream two's-complement overflow
//   zero       block -> downstream sum == 0
//
// Modports:
//   master     the environment: drives operands and out_ready
//   slave      the arithmetic block
// ----------------------------------------------------------------------------
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 14
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/cla_addsub_pipe.sv
// ----------------------------------------------------------------------------
// cla_addsub_pipe
//
// Purpose:
//   Two-stage pipelined carry-lookahead adder/subtractor.
//   {cout, sum} = a + bb + c0 with bb = sub ? ~b : b and c0 = sub ? ~cin : cin,
//   so sub=1 gives a - b - cin with cout = 1 meaning "no borrow".
//   Stage 1 resolves the low LO_W bits and registers the carry between the
//   halves; stage 2 resolves the high bits and the flags. Both sides use a
//   valid/ready handshake; one bundle per cycle when out_ready stays high.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (clears all valid bits and outputs)
//   io      cla_addsub_pipe_if.slave bundle (operands in, result out)
//
// Parameters:
//   WIDTH   operand/result width, even and >= 4
//   LO_W    width of the low slice resolved in stage 1
//
// Configuration macro:
//   CLA_ADDSUB_SAT_EN  when defined, an overflowing result is clamped to the
//                      signed extreme in stage 2 (ovf still reported, zero
//                      follows the clamped value). When undefined the result
//                      wraps modulo 2^WIDTH and no clamp logic exists.
// ----------------------------------------------------------------------------

// Carry-lookahead slice built from 4-bit generate/propagate groups. Inside a
// group every carry is a flat sum-of-products of the bit generates/propagates
// and the group carry-in; group carries are formed from group G/P terms.
module cla_addsub_slice #(
  parameter int W = 7
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;
  logic          term;

  // Bit and group generate/propagate, group carries, then per-bit carries
  // expanded as products so no carry ripples through a group.
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    gg   = '0;
    gp   = '0;
    gc   = '0;
    c    = '0;
    term = 1'b0;
    gc[0] = ci;
    for (int k = 0; k < NG; k++) begin
      gp[k] = 1'b1;
      for (int j = 4 * k; (j < 4 * k + 4) && (j < W); j++) begin
        gg[k] = g[j] | (p[j] & gg[k]);
        gp[k] = gp[k] & p[j];
      end
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int i = 0; i < W; i++) begin
      c[i] = gc[i/4];
      for (int j = (i / 4) * 4; j < i; j++) begin
        c[i] = c[i] & p[j];
      end
      for (int j = (i / 4) * 4; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
    s  = p ^ c;
    co = gc[NG];
  end

endmodule

module cla_addsub_pipe #(
  parameter int WIDTH = 14,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cla_addsub_pipe_if.slave     io
);

  localparam int HI_W = WIDTH - LO_W;

  // Operand conditioning: subtraction is a + ~b + ~cin.
  logic [WIDTH-1:0] bb;
  logic             c0;

  // Stage 1 state.
  logic             s1_valid;
  logic [HI_W-1:0]  a_hi;
  logic [HI_W-1:0]  bb_hi;
  logic [LO_W-1:0]  sum_lo;
  logic             c_mid;

  // Stage 2 (output) state.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Combinational slice results.
  logic [LO_W-1:0]  lo_sum;
  logic             lo_carry;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_carry;
  logic             ovf_w;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] result;

  logic             adv1;
  logic             adv2;

  // Effective operand and carry for add/subtract.
  always_comb begin
    bb = io.sub ? ~io.b : io.b;
    c0 = io.sub ? ~io.cin : io.cin;
  end

  cla_addsub_slice #(.W(LO_W)) u_lo (
    .x  (io.a[LO_W-1:0]),
    .y  (bb[LO_W-1:0]),
    .ci (c0),
    .s  (lo_sum),
    .co (lo_carry)
  );

  cla_addsub_slice #(.W(HI_W)) u_hi (
    .x  (a_hi),
    .y  (bb_hi),
    .ci (c_mid),
    .s  (hi_sum),
    .co (hi_carry)
  );

  // Signed overflow only happens when both effective operands share a sign
  // and the result sign differs from it.
  always_comb begin
    full_sum = {hi_sum, sum_lo};
    ovf_w    = (a_hi[HI_W-1] == bb_hi[HI_W-1]) && (hi_sum[HI_W-1] != a_hi[HI_W-1]);
`ifdef CLA_ADDSUB_SAT_EN
    // Clamp toward the sign of a: positive operand overflows upward.
    if (ovf_w) begin
      result = a_hi[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = full_sum;
    end
`else
    result = full_sum;
`endif
  end

  // A stage may load when its successor is empty or is draining this cycle.
  always_comb begin
    adv2 = !out_valid_q || io.out_ready;
    adv1 = !s1_valid || adv2;
  end

  assign io.in_ready  = adv1;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;

  // Pipeline registers. Data registers only load on a real transfer so the
  // output bundle stays frozen while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      a_hi        <= '0;
      bb_hi       <= '0;
      sum_lo      <= '0;
      c_mid       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= io.in_valid;
        if (io.in_valid) begin
          a_hi   <= io.a[WIDTH-1:LO_W];
          bb_hi  <= bb[WIDTH-1:LO_W];
          sum_lo <= lo_sum;
          c_mid  <= lo_carry;
        end
      end
      if (adv2) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          sum_q  <= result;
          cout_q <= hi_carry;
          ovf_q  <= ovf_w;
          zero_q <= (result == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_cla_addsub_pipe
//
// Purpose:
//   Self-checking bench for cla_addsub_pipe: reset state, directed add/sub
//   vectors with hand-computed results and exact latency, a 50-bundle stream
//   with a 3-cycle downstream stall, and a reset that drops in-flight bundles.
// ----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

  localparam int W = 14;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cla_addsub_pipe_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {cout, ovf, zero, sum}, computed with plain
  // integer and signed-range arithmetic.
  function automatic logic [31:0] refModel(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                           input logic cin_v, input logic sub_v);
    int ua, ub, ci, r, sa, sb, sr;
    logic [W-1:0] s;
    logic co, ov;
    ua = int'(a_v);
    ub = int'(b_v);
    ci = cin_v ? 1 : 0;
    sa = a_v[W-1] ? ua - 16384 : ua;
    sb = b_v[W-1] ? ub - 16384 : ub;
    if (!sub_v) begin
      r  = ua + ub + ci;
      co = (r >= 16384);
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      co = (ua >= ub + ci);
      sr = sa - sb - ci;
    end
    s  = r[W-1:0];
    ov = (sr > 8191) || (sr < -8192);
`ifdef CLA_ADDSUB_SAT_EN
    if (ov) s = a_v[W-1] ? 14'h2000 : 14'h1FFF;
`endif
    return {16'b0, co, ov, (s == '0), s};
  endfunction

  // Present one bundle and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                               input logic cin_v, input logic sub_v);
    int n;
    @(negedge clk);
    bus.a        = a_v;
    bus.b        = b_v;
    bus.cin      = cin_v;
    bus.sub      = sub_v;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("accept_wait", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Directed vector: exact two-edge latency, then every result field.
  task automatic runVector(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                           input logic cin_v, input logic sub_v, input logic [W-1:0] e_sum,
                           input logic e_cout, input logic e_ovf, input logic e_zero);
    applyStimulus(a_v, b_v, cin_v, sub_v);
    @(negedge clk);
    checkOutput({tag, "_lat1"}, {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    checkOutput({tag, "_sum"},  {18'b0, bus.sum},  {18'b0, e_sum});
    checkOutput({tag, "_cout"}, {31'b0, bus.cout}, {31'b0, e_cout});
    checkOutput({tag, "_ovf"},  {31'b0, bus.ovf},  {31'b0, e_ovf});
    checkOutput({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, e_zero});
  endtask

  initial begin
    int sent, got, cyc;
    logic need_new;
    logic held_valid;
    logic [31:0] held_val;
    logic [31:0] obs;
    logic [31:0] expq[$];
    logic [W-1:0] ra, rb;
    logic rc, rs;

    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_sum",       {18'b0, bus.sum}, 32'd0);
    checkOutput("rst_flags",     {29'b0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    checkOutput("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);

    // Directed vectors.
    runVector("add_wrap", 14'h3FFF, 14'h0001, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_ADDSUB_SAT_EN
    runVector("pos_ovf",  14'h1FFF, 14'h0001, 1'b0, 1'b0, 14'h1FFF, 1'b0, 1'b1, 1'b0);
    runVector("neg_ovf",  14'h2000, 14'h0001, 1'b0, 1'b1, 14'h2000, 1'b1, 1'b1, 1'b0);
`else
    runVector("pos_ovf",  14'h1FFF, 14'h0001, 1'b0, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
    runVector("neg_ovf",  14'h2000, 14'h0001, 1'b0, 1'b1, 14'h1FFF, 1'b1, 1'b1, 1'b0);
`endif
    runVector("sub_borrow", 14'h0005, 14'h0007, 1'b0, 1'b1, 14'h3FFE, 1'b0, 1'b0, 1'b0);
    runVector("sub_bin",    14'h0007, 14'h0005, 1'b1, 1'b1, 14'h0001, 1'b1, 1'b0, 1'b0);
    runVector("mid_carry",  14'h007F, 14'h0001, 1'b0, 1'b0, 14'h0080, 1'b0, 1'b0, 1'b0);
    runVector("sub_equal",  14'h1234, 14'h1234, 1'b0, 1'b1, 14'h0000, 1'b1, 1'b0, 1'b1);
    runVector("add_cin",    14'h0F0F, 14'h00F1, 1'b1, 1'b0, 14'h1001, 1'b0, 1'b0, 1'b0);

    // Streaming with a 3-cycle stall: order, hold stability, no loss.
    sent = 0;
    got = 0;
    cyc = 0;
    need_new = 1'b1;
    held_valid = 1'b0;
    held_val = '0;
    @(negedge clk);
    while (got < 50 && cyc < 400) begin
      bus.out_ready = !(cyc >= 10 && cyc < 13);
      if (sent < 50 && need_new) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        bus.a = ra;
        bus.b = rb;
        bus.cin = rc;
        bus.sub = rs;
        bus.in_valid = 1'b1;
        need_new = 1'b0;
      end
      if (sent >= 50) bus.in_valid = 1'b0;
      #1;
      obs = {16'b0, bus.cout, bus.ovf, bus.zero, bus.sum};
      if (cyc == 12) checkOutput("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      if (held_valid) checkOutput("stall_hold", obs, held_val);
      held_valid = bus.out_valid && !bus.out_ready;
      held_val = obs;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() > 0) checkOutput($sformatf("stream_%0d", got), obs, expq.pop_front());
        else checkOutput("stream_extra", {31'b0, bus.out_valid}, 32'd0);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(refModel(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
        need_new = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("stream_sent", sent, 32'd50);
    checkOutput("stream_got", got, 32'd50);
    checkOutput("stream_cycles", {31'b0, (cyc < 70)}, 32'd1);

    // Reset with two bundles in flight: nothing may come out afterwards.
    bus.out_ready = 1'b0;
    applyStimulus(14'h0011, 14'h0022, 1'b0, 1'b0);
    applyStimulus(14'h0033, 14'h0044, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_full", {30'b0, bus.out_valid, bus.in_ready}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("midrst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_no_stale_%0d", i), {31'b0, bus.out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
